// File: rtl/bist_fault_logger_pkg.sv
// Shared definitions for the BIST fault logger.
//   - state_t : logger FSM states (IDLE, LOG, HOLD)
//   - DEF_*   : default widths and log depth
package bist_fault_logger_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOG  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/bist_fault_logger_if.sv
// Bus between a BIST controller/reader and the fault logger.
//   comparator side : test_active, cmp_valid, error, fail_addr, expected, actual
//   readout side    : rd_req -> rd_valid, rd_addr, rd_expected, rd_actual
//   status          : log_empty, log_full, overflow, err_count, any_fail, done
// master = controller/reader, slave = logger.
interface bist_fault_logger_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic              test_active;
    logic              cmp_valid;
    logic              error;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] expected;
    logic [DATA_W-1:0] actual;
    logic              rd_req;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_expected;
    logic [DATA_W-1:0] rd_actual;
    logic              log_empty;
    logic              log_full;
    logic              overflow;
    logic [CNT_W-1:0]  err_count;
    logic              any_fail;
    logic              done;

    modport master (
        output test_active, cmp_valid, error, fail_addr, expected, actual, rd_req,
        input  rd_valid, rd_addr, rd_expected, rd_actual,
        input  log_empty, log_full, overflow, err_count, any_fail, done
    );

    modport slave (
        input  test_active, cmp_valid, error, fail_addr, expected, actual, rd_req,
        output rd_valid, rd_addr, rd_expected, rd_actual,
        output log_empty, log_full, overflow, err_count, any_fail, done
    );

endinterface

// File: rtl/bist_fault_logger_fault_fifo.sv
// Fault record store: synchronous-write, registered-read FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   clr           : discard all records (pointers and occupancy to zero)
//   push, wdata   : write one record (accepted when not full, or full with a pop)
//   pop           : read one record (ignored when empty)
//   rdata,rd_valid: popped record, valid for one cycle after an accepted pop
//   full, empty   : registered occupancy flags
//   count         : occupancy, log2(DEPTH)+1 bits
module fault_fifo #(
    parameter int unsigned W     = 26,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count_nxt;
    logic          pop_ok;
    logic          push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage is not reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
            rdata    <= '0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr];
            end
            rd_valid <= pop_ok;
            count    <= count_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            empty    <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/bist_fault_logger.sv
// BIST fault logger top.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bist_fault_logger_if (comparator inputs,
//              record readout, occupancy/overflow/count/fail/done status)
// Records {fail_addr, expected, actual} of every comparator mismatch seen while
// a test is active, counts them (saturating), and freezes results in HOLD.
module bist_fault_logger
    import bist_fault_logger_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    bist_fault_logger_if.slave bus
);
    localparam int unsigned REC_W = ADDR_W + 2 * DATA_W;

    state_t                state;
    state_t                state_nxt;
    logic                  clear;
    logic                  fault;
    logic                  pop_ok;
    logic                  drop;
    logic [REC_W-1:0]      rec_out;
    logic [$clog2(DEPTH):0] occupancy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.test_active)  state_nxt = LOG;
            LOG:  if (!bus.test_active) state_nxt = HOLD;
            HOLD: if (bus.test_active)  state_nxt = LOG;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. A fault needs test_active as well as LOG, so a mismatch in
    // the cycle test_active falls is not recorded.
    always_comb begin
        clear    = 1'b0;
        fault    = 1'b0;
        bus.done = 1'b0;
        unique case (state)
            IDLE: clear = bus.test_active;
            LOG:  fault = bus.test_active && bus.cmp_valid && bus.error;
            HOLD: begin
                clear    = bus.test_active;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    assign pop_ok = bus.rd_req && !bus.log_empty;
    assign drop   = fault && bus.log_full && !pop_ok;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bus.err_count <= '0;
            bus.overflow  <= 1'b0;
            bus.any_fail  <= 1'b0;
        end else if (fault) begin
            if (bus.err_count != '1) begin
                bus.err_count <= bus.err_count + 1'b1;
            end
            bus.any_fail <= 1'b1;
            if (drop) begin
                bus.overflow <= 1'b1;
            end
        end
    end

    fault_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear),
        .push     (fault),
        .pop      (bus.rd_req),
        .wdata    ({bus.fail_addr, bus.expected, bus.actual}),
        .rdata    (rec_out),
        .rd_valid (bus.rd_valid),
        .full     (bus.log_full),
        .empty    (bus.log_empty),
        .count    (occupancy)
    );

    assign {bus.rd_addr, bus.rd_expected, bus.rd_actual} = rec_out;

    // Occupancy is exposed through the flags only.
    logic unused_occ;
    assign unused_occ = ^occupancy;

endmodule

// File: tb/tb_bist_fault_logger.sv
// Directed self-checking bench for bist_fault_logger. A second instance with a
// 4-bit error counter receives identical stimulus to exercise saturation.
module tb_bist_fault_logger;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    bist_fault_logger_if #(.ADDR_W(10), .DATA_W(8), .CNT_W(16)) bus ();
    bist_fault_logger_if #(.ADDR_W(10), .DATA_W(8), .CNT_W(4))  bus4 ();

    assign bus4.test_active = bus.test_active;
    assign bus4.cmp_valid   = bus.cmp_valid;
    assign bus4.error       = bus.error;
    assign bus4.fail_addr   = bus.fail_addr;
    assign bus4.expected    = bus.expected;
    assign bus4.actual      = bus.actual;
    assign bus4.rd_req      = bus.rd_req;

    bist_fault_logger #(.ADDR_W(10), .DATA_W(8), .DEPTH(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    bist_fault_logger #(.ADDR_W(10), .DATA_W(8), .DEPTH(8), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fault(input logic [9:0] a, input logic [7:0] e, input logic [7:0] act);
        bus.cmp_valid = 1'b1;
        bus.error     = 1'b1;
        bus.fail_addr = a;
        bus.expected  = e;
        bus.actual    = act;
        step();
        bus.cmp_valid = 1'b0;
        bus.error     = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [9:0] a, input logic [7:0] e,
                           input logic [7:0] act);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_addr"},  32'(bus.rd_addr), 32'(a));
        chk({tag, "_exp"},   32'(bus.rd_expected), 32'(e));
        chk({tag, "_act"},   32'(bus.rd_actual), 32'(act));
        step();
        chk({tag, "_valid_drop"}, 32'(bus.rd_valid), 32'd0);
    endtask

    task automatic restart();
        bus.test_active = 1'b0;
        step();
        bus.test_active = 1'b1;
        step();
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        rst             = 1'b1;
        bus.test_active = 1'b0;
        bus.cmp_valid   = 1'b0;
        bus.error       = 1'b0;
        bus.fail_addr   = '0;
        bus.expected    = '0;
        bus.actual      = '0;
        bus.rd_req      = 1'b0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_empty",    32'(bus.log_empty), 32'd1);
        chk("rst_full",     32'(bus.log_full), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_addr",  32'(bus.rd_addr), 32'd0);
        chk("rst_err",      32'(bus.err_count), 32'd0);
        chk("rst_done",     32'(bus.done), 32'd0);
        chk("rst_any",      32'(bus.any_fail), 32'd0);
        chk("rst_ovf",      32'(bus.overflow), 32'd0);

        // Clean run of 20 cycles
        bus.test_active = 1'b1;
        step();
        chk("clean_done_in_log", 32'(bus.done), 32'd0);
        for (int i = 0; i < 19; i++) step();
        bus.test_active = 1'b0;
        step();
        chk("clean_err",   32'(bus.err_count), 32'd0);
        chk("clean_any",   32'(bus.any_fail), 32'd0);
        chk("clean_empty", 32'(bus.log_empty), 32'd1);
        chk("clean_done",  32'(bus.done), 32'd1);

        // Three faults, non-error compare ignored, FIFO-order readout
        bus.test_active = 1'b1;
        step();
        chk("t3_done", 32'(bus.done), 32'd0);
        fault(10'h005, 8'hAA, 8'hAB);
        fault(10'h1FF, 8'hAA, 8'hAB);
        fault(10'h3FF, 8'hAA, 8'hAB);
        bus.cmp_valid = 1'b1;
        bus.error     = 1'b0;
        step();
        bus.cmp_valid = 1'b0;
        bus.error     = 1'b1;
        step();
        bus.error     = 1'b0;
        chk("t3_err",   32'(bus.err_count), 32'd3);
        chk("t3_any",   32'(bus.any_fail), 32'd1);
        chk("t3_empty", 32'(bus.log_empty), 32'd0);
        pop_chk("t3_pop0", 10'h005, 8'hAA, 8'hAB);
        pop_chk("t3_pop1", 10'h1FF, 8'hAA, 8'hAB);
        pop_chk("t3_pop2", 10'h3FF, 8'hAA, 8'hAB);
        chk("t3_empty_after", 32'(bus.log_empty), 32'd1);
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        chk("t3_pop_empty", 32'(bus.rd_valid), 32'd0);

        // Fault in the same cycle test_active falls is not logged
        bus.test_active = 1'b0;
        fault(10'h077, 8'h11, 8'h22);
        chk("fall_err",   32'(bus.err_count), 32'd3);
        chk("fall_empty", 32'(bus.log_empty), 32'd1);
        chk("fall_done",  32'(bus.done), 32'd1);

        // Overflow: 12 faults into 8 slots
        bus.test_active = 1'b1;
        step();
        chk("ovf_clr_err", 32'(bus.err_count), 32'd0);
        chk("ovf_clr_any", 32'(bus.any_fail), 32'd0);
        for (int i = 0; i < 12; i++) fault(10'(32'h010 + i), 8'(i), 8'(8'hF0 + i));
        chk("ovf_err",  32'(bus.err_count), 32'd12);
        chk("ovf_full", 32'(bus.log_full), 32'd1);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 8; i++) pop_chk("ovf_pop", 10'(32'h010 + i), 8'(i), 8'(8'hF0 + i));
        chk("ovf_empty", 32'(bus.log_empty), 32'd1);
        chk("ovf_notfull", 32'(bus.log_full), 32'd0);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Full log with simultaneous push and pop
        restart();
        chk("sim_clr_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 8; i++) fault(10'(32'h020 + i), 8'h5A, 8'(i));
        chk("sim_full_pre", 32'(bus.log_full), 32'd1);
        chk("sim_ovf_pre",  32'(bus.overflow), 32'd0);
        bus.rd_req = 1'b1;
        fault(10'h028, 8'h5A, 8'h08);
        bus.rd_req = 1'b0;
        chk("sim_valid", 32'(bus.rd_valid), 32'd1);
        chk("sim_addr",  32'(bus.rd_addr), 32'h020);
        chk("sim_full",  32'(bus.log_full), 32'd1);
        chk("sim_ovf",   32'(bus.overflow), 32'd0);
        chk("sim_err",   32'(bus.err_count), 32'd9);
        step();
        for (int i = 1; i < 9; i++) pop_chk("sim_pop", 10'(32'h020 + i), 8'h5A, 8'(i));
        chk("sim_empty", 32'(bus.log_empty), 32'd1);

        // Counter saturation on the 4-bit instance
        restart();
        for (int i = 0; i < 20; i++) fault(10'(32'h040 + i), 8'h33, 8'h44);
        chk("sat_err16", 32'(bus.err_count), 32'd20);
        chk("sat_err4",  32'(bus4.err_count), 32'hF);
        chk("sat_ovf4",  32'(bus4.overflow), 32'd1);
        restart();
        chk("sat_clr4",  32'(bus4.err_count), 32'd0);
        chk("sat_clr16", 32'(bus.err_count), 32'd0);
        chk("sat_clr_empty", 32'(bus.log_empty), 32'd1);

        // Reset mid-test
        fault(10'h030, 8'h01, 8'h02);
        fault(10'h031, 8'h01, 8'h02);
        fault(10'h032, 8'h01, 8'h02);
        chk("mid_err_pre", 32'(bus.err_count), 32'd3);
        rst             = 1'b1;
        bus.test_active = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_err",      32'(bus.err_count), 32'd0);
        chk("mid_err4",     32'(bus4.err_count), 32'd0);
        chk("mid_any",      32'(bus.any_fail), 32'd0);
        chk("mid_empty",    32'(bus.log_empty), 32'd1);
        chk("mid_full",     32'(bus.log_full), 32'd0);
        chk("mid_ovf",      32'(bus.overflow), 32'd0);
        chk("mid_done",     32'(bus.done), 32'd0);
        chk("mid_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("mid_rd_addr",  32'(bus.rd_addr), 32'd0);
        chk("mid_rd_exp",   32'(bus.rd_expected), 32'd0);
        chk("mid_rd_act",   32'(bus.rd_actual), 32'd0);
        // From IDLE with test_active low the FSM stays put; from LOG it would reach HOLD.
        step();
        chk("mid_idle", 32'(bus.done), 32'd0);
        bus.test_active = 1'b1;
        step();
        fault(10'h0AB, 8'hC3, 8'h3C);
        chk("mid_new_err", 32'(bus.err_count), 32'd1);
        pop_chk("mid_pop", 10'h0AB, 8'hC3, 8'h3C);
        chk("mid_new_empty", 32'(bus.log_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
